invsqrt_stream_adapter: RTL and testbench

Streaming front/back end for the fixed-latency inverse-square-root pipeline. Accepts 32-bit IEEE-754 singles on a valid/ready input stream and issues them to the pipeline's `valid`/`float_in` port. Collects the pipeline's `ready`/`float_out` result, restores the 32-bit format and patches special cases. Buffers results in a FIFO for a backpressured valid/ready output stream. Credit-based issue guarantees the non-stallable pipeline never overruns the FIFO.

---
 rtl/invsqrt_pkg.sv | 50 +++++
 rtl/sync_fifo.sv | 53 +++++
 rtl/invsqrt_stream_adapter.sv | 103 ++++++++++
 tb/tb_invsqrt_stream_adapter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/invsqrt_pkg.sv
// Shared types and constants for the inverse-square-root stream adapter.
package invsqrt_pkg;

    localparam int unsigned INVSQRT_LATENCY = 5;

    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_NINF = 32'hFF80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        TagNorm  = 2'd0,
        TagPzero = 2'd1,
        TagNzero = 2'd2,
        TagNeg   = 2'd3
    } tag_e;

    // flush marks slots emptied by reset, so stale pipeline results are dropped silently
    typedef struct packed {
        logic flush;
        logic valid;
        tag_e tag;
    } tag_ent_t;

    function automatic tag_e classify(input logic [31:0] f);
        tag_e t;
        if (f == 32'h0000_0000) begin
            t = TagPzero;
        end else if (f == 32'h8000_0000) begin
            t = TagNzero;
        end else if (f[31]) begin
            t = TagNeg;
        end else begin
            t = TagNorm;
        end
        return t;
    endfunction

    function automatic logic [31:0] patch(input tag_e t, input logic [30:0] mag);
        logic [31:0] r;
        unique case (t)
            TagNorm:  r = {1'b0, mag};
            TagPzero: r = FP_PINF;
            TagNzero: r = FP_NINF;
            TagNeg:   r = FP_QNAN;
            default:  r = FP_QNAN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with output taken straight from storage flops.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW + 1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // a pop frees the slot this cycle, so a push into a full FIFO is still taken
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW + 1)'(w_do_push) - (AW + 1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/invsqrt_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency, non-stallable inverse-sqrt pipeline
// with special-case patching and credit-based issue into a result FIFO.
module invsqrt_stream_adapter
    import invsqrt_pkg::*;
#(
    parameter int unsigned LATENCY = INVSQRT_LATENCY,
    parameter int unsigned DEPTH   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic [31:0] i_s_data,
    output logic        o_pipe_valid,
    output logic [31:0] o_pipe_float_in,
    input  logic [30:0] i_pipe_float_out,
    input  logic        i_pipe_ready,
    output logic        o_m_valid,
    input  logic        i_m_ready,
    output logic [31:0] o_m_data,
    output logic        o_err
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          r_pipe_valid;
    logic [31:0]   r_pipe_float_in;
    tag_e          r_pipe_tag;
    tag_ent_t      r_sr [LATENCY];
    logic [CW-1:0] r_inflight;
    logic          r_err;

    logic          w_accept;
    tag_ent_t      w_tail;
    logic          w_push;
    logic          w_pop;
    logic          w_spurious;
    logic          w_overflow;
    logic          w_retire;
    logic [31:0]   w_wdata;
    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_occ;
    logic          w_fifo_full;
    logic          w_fifo_empty;

    // occupancy counts issued-but-unreturned results, so the pipeline can never overrun the FIFO
    assign w_occ     = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign o_s_ready = !i_rst && (w_occ < (CW + 1)'(DEPTH));
    assign w_accept  = i_s_valid && o_s_ready;

    assign w_tail     = r_sr[LATENCY-1];
    assign w_push     = i_pipe_ready && !w_tail.flush;
    assign w_spurious = w_push && !w_tail.valid;
    assign w_retire   = i_pipe_ready && w_tail.valid;
    assign w_pop      = o_m_valid && i_m_ready;
    assign w_overflow = w_push && w_fifo_full && !w_pop;
    assign w_wdata    = patch(w_tail.tag, i_pipe_float_out);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_valid    <= 1'b0;
            r_pipe_float_in <= '0;
            r_pipe_tag      <= TagNorm;
            r_inflight      <= '0;
            r_err           <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                r_sr[i] <= '{flush: 1'b1, valid: 1'b0, tag: TagNorm};
            end
        end else begin
            r_pipe_valid <= w_accept;
            r_pipe_tag   <= w_accept ? classify(i_s_data) : TagNorm;
            if (w_accept) begin
                r_pipe_float_in <= i_s_data;
            end
            r_sr[0] <= '{flush: 1'b0, valid: r_pipe_valid, tag: r_pipe_tag};
            for (int i = 1; i < LATENCY; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_retire);
            r_err      <= r_err | w_spurious | w_overflow;
        end
    end

    assign o_pipe_valid    = r_pipe_valid;
    assign o_pipe_float_in = r_pipe_float_in;
    assign o_err           = r_err;
    assign o_m_valid       = !w_fifo_empty;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (o_m_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_invsqrt_stream_adapter.sv
// Scoreboard bench for invsqrt_stream_adapter with a 5-cycle stub pipeline.
module tb_invsqrt_stream_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        pipe_valid;
    logic [31:0] pipe_float_in;
    logic [30:0] pipe_float_out;
    logic        pipe_ready;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        err;

    logic [4:0]  stub_v = '0;
    logic [30:0] stub_d [5];
    logic        inj = 1'b0;
    logic [30:0] inj_d = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    logic        held = 1'b0;
    logic [31:0] held_data = '0;
    int          max_inflight = 0;

    always #5 clk = ~clk;

    invsqrt_stream_adapter #(.LATENCY(5), .DEPTH(8)) u_dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_s_valid        (s_valid),
        .o_s_ready        (s_ready),
        .i_s_data         (s_data),
        .o_pipe_valid     (pipe_valid),
        .o_pipe_float_in  (pipe_float_in),
        .i_pipe_float_out (pipe_float_out),
        .i_pipe_ready     (pipe_ready),
        .o_m_valid        (m_valid),
        .i_m_ready        (m_ready),
        .o_m_data         (m_data),
        .o_err            (err)
    );

    // Stub pipeline: not reset, like the real non-stallable datapath
    always @(posedge clk) begin
        stub_v    <= {stub_v[3:0], pipe_valid};
        stub_d[0] <= pipe_float_in[30:0] ^ 31'h1;
        for (int i = 1; i < 5; i++) stub_d[i] <= stub_d[i-1];
    end
    assign pipe_ready     = stub_v[4] | inj;
    assign pipe_float_out = inj ? inj_d : stub_d[4];

    function automatic logic [31:0] model(input logic [31:0] x);
        if (x == 32'h0000_0000) return 32'h7F80_0000;
        if (x == 32'h8000_0000) return 32'hFF80_0000;
        if (x[31]) return 32'h7FC0_0000;
        return {1'b0, x[30:0] ^ 31'h1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected results and checks hold-stability under backpressure
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) check("m_data_stable", m_data, held_data);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_m_valid", {31'b0, m_valid}, 32'd0);
                else check("m_data", m_data, exp_q.pop_front());
            end
            held      = m_valid && !m_ready;
            held_data = m_data;
            if (int'(u_dut.r_inflight) > max_inflight) max_inflight = int'(u_dut.r_inflight);
        end
    end

    // One cycle of stimulus; starts and ends just after a rising edge
    task automatic drive(input logic v, input logic [31:0] d, output logic acc);
        s_valid = v;
        s_data  = d;
        @(negedge clk);
        acc = v && s_ready;
        if (acc) exp_q.push_back(model(d));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
        check(name, exp_q.size(), 0);
    endtask

    task automatic latency_run(input logic [31:0] d, input logic exp_err, input string name);
        int   first_mv;
        logic acc;
        first_mv = -1;
        drive(1'b1, d, acc);
        check({name, "_accept"}, {31'b0, acc}, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) begin
                check({name, "_pipe_valid_c1"}, {31'b0, pipe_valid}, 32'd1);
                check({name, "_pipe_float_in"}, pipe_float_in, d);
            end
            if (k == 2) check({name, "_pipe_valid_pulse"}, {31'b0, pipe_valid}, 32'd0);
            if (first_mv < 0 && m_valid) first_mv = k;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        check({name, "_m_valid_cycle"}, first_mv, 7);
        check({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    initial begin
        logic acc;
        int   n_acc;
        // Reset values
        idle(2);
        @(negedge clk);
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_pipe_valid", {31'b0, pipe_valid}, 32'd0);
        check("rst_pipe_float_in", pipe_float_in, 32'd0);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", {31'b0, s_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single operand latency
        latency_run(32'h4080_0000, 1'b0, "single");
        wait_drain("single_drain");

        // Special-case patching, back to back
        drive(1'b1, 32'h0000_0000, acc);
        drive(1'b1, 32'h8000_0000, acc);
        drive(1'b1, 32'hC000_0000, acc);
        drive(1'b1, 32'h3F80_0000, acc);
        wait_drain("special_drain");

        // Backpressure: credits stop issue at DEPTH
        m_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h3F00_0000 + 32'(i), acc);
            if (acc) n_acc++;
        end
        idle(10);
        check("bp_accepts", n_acc, 8);
        check("bp_fifo_count", 32'(u_dut.w_fifo_count), 32'd8);
        check("bp_s_ready_low", {31'b0, s_ready}, 32'd0);
        check("bp_m_valid", {31'b0, m_valid}, 32'd1);
        check("bp_err", {31'b0, err}, 32'd0);
        m_ready = 1'b1;
        wait_drain("bp_drain");
        idle(2);
        latency_run(32'h4100_0000, 1'b0, "bp_resume");
        wait_drain("bp_resume_drain");

        // Sustained throughput
        n_acc = 0;
        max_inflight = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h4000_0000 + 32'(i * 3), acc);
            if (acc) n_acc++;
        end
        check("tp_accepts", n_acc, 100);
        wait_drain("tp_drain");
        check("tp_inflight_le_7", {31'b0, max_inflight <= 7}, 32'd1);
        idle(8);

        // Spurious pipe_ready sets sticky err
        @(negedge clk);
        check("spur_err_before", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        inj   = 1'b1;
        inj_d = 31'h0123_4567;
        exp_q.push_back({1'b0, 31'h0123_4567});
        @(posedge clk);
        #1;
        inj = 1'b0;
        @(negedge clk);
        check("spur_err_next", {31'b0, err}, 32'd1);
        idle(6);
        check("spur_err_sticky", {31'b0, err}, 32'd1);
        wait_drain("spur_drain");

        // Reset with results in flight
        drive(1'b1, 32'h4040_0000, acc);
        drive(1'b1, 32'h4050_0000, acc);
        drive(1'b1, 32'h4060_0000, acc);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_s_ready", {31'b0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_s_ready_after", {31'b0, s_ready}, 32'd1);
        check("midrst_err_cleared", {31'b0, err}, 32'd0);
        idle(12);
        check("midrst_err_stays", {31'b0, err}, 32'd0);
        check("midrst_m_valid", {31'b0, m_valid}, 32'd0);
        latency_run(32'h3E80_0000, 1'b0, "post_rst");
        wait_drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
